// File: rtl/cylon_gen_if.sv
// Control/status bundle for the front-panel cylon LED generator.
// The bench or host drives the master side; cylon_gen sits on the slave side.
interface cylon_gen_if #(
  parameter int MXLED = 8
);
  logic             enable;
  logic [1:0]       rate;
  logic [1:0]       mode;
  logic [MXLED-1:0] q;
  logic             sweep_done;

  modport master (
    output enable, rate, mode,
    input  q, sweep_done
  );

  modport slave (
    input  enable, rate, mode,
    output q, sweep_done
  );
endinterface

// File: rtl/cylon_gen.sv
// Multi-mode bouncing LED sequence generator with a lamp-test phase after reset.
// It also pulses sweep_done once per full bounce.
module cylon_gen #(
  parameter int MXLED = 8,
  parameter int MXPRE = 21
) (
  input  logic        clock,
  input  logic        reset,
  cylon_gen_if.slave  bus
);
  localparam int MXPOS = (MXLED > 1) ? $clog2(MXLED) : 1;
  localparam logic [MXPOS-1:0] TOP  = MXPOS'(MXLED - 1);
  localparam logic [MXPOS-1:0] NEXT = MXPOS'(MXLED - 2);
  localparam logic [MXPOS-1:0] ONE  = MXPOS'(1);

  typedef enum logic {LAMP, RUN} state_t;

  state_t           state;
  logic [MXPRE-1:0] pre;
  logic [MXPOS-1:0] pos;
  logic             dir_dn;
  logic [1:0]       mode_ff;
  logic [MXLED-1:0] q_r;
  logic             sd_r;
  logic [MXPRE:0]   sum;
  logic             tick;
  logic [MXLED-1:0] pat;

  // A carry-out tick cannot be skipped by any rate, unlike an equality compare.
  assign sum  = {1'b0, pre}
              + (MXPRE+1)'(bus.rate)
              + (MXPRE+1)'(1);
  assign tick = sum[MXPRE];

  always_comb begin
    pat = '0;
    case (mode_ff)
      2'd0:
        for (int i = 0; i < MXLED; i++)
          pat[i] = (i == int'(pos));
      2'd1:
        for (int i = 0; i < MXLED; i++)
          pat[i] = (i == int'(pos))
                || (i == MXLED - 1 - int'(pos));
      2'd2:
        for (int i = 0; i < MXLED; i++)
          pat[i] = (i <= int'(pos));
      default:
        pat = pos[0] ? '0 : '1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= LAMP;
      pre     <= '0;
      pos     <= '0;
      dir_dn  <= 1'b0;
      mode_ff <= bus.mode;
      q_r     <= '1;
      sd_r    <= 1'b0;
    end else if (bus.enable) begin
      sd_r    <= 1'b0;
      mode_ff <= bus.mode;
      unique case (state)
        LAMP: begin
          pre <= sum[MXPRE-1:0];
          q_r <= '1;
          if (tick) begin
            state  <= RUN;
            pos    <= '0;
            dir_dn <= 1'b0;
          end
        end
        RUN: begin
          q_r <= pat;
          if (bus.mode != mode_ff) begin
            pos    <= '0;
            dir_dn <= 1'b0;
            pre    <= '0;
          end else begin
            pre <= sum[MXPRE-1:0];
            if (tick) begin
              if (int'(pos) > MXLED - 1) begin
                pos    <= '0;
                dir_dn <= 1'b0;
              end else if (!dir_dn) begin
                if (pos == TOP) begin
                  pos    <= NEXT;
                  dir_dn <= 1'b1;
                end else begin
                  pos <= pos + ONE;
                end
              end else begin
                if (pos == ONE) begin
                  pos    <= '0;
                  dir_dn <= 1'b0;
                  sd_r   <= 1'b1;
                end else begin
                  pos <= pos - ONE;
                end
              end
            end
          end
        end
      endcase
    end else begin
      sd_r <= 1'b0;
    end
  end

  assign bus.q          = q_r;
  assign bus.sweep_done = sd_r;
endmodule

// File: tb/tb_cylon_gen.sv
// Directed bench for cylon_gen: MXLED=8 and MXLED=5 instances, MXPRE=2.
// Expected LED sequences are hand-written tables.
module tb_cylon_gen;
  logic clock;
  logic rst8;
  logic rst5;
  int   errors;
  int   checks;

  cylon_gen_if #(.MXLED(8)) i8 ();
  cylon_gen_if #(.MXLED(5)) i5 ();

  cylon_gen #(.MXLED(8), .MXPRE(2)) u8 (
    .clock (clock),
    .reset (rst8),
    .bus   (i8.slave)
  );

  cylon_gen #(.MXLED(5), .MXPRE(2)) u5 (
    .clock (clock),
    .reset (rst5),
    .bus   (i5.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic run8(input logic [1:0] r,
                      input logic [1:0] m,
                      input logic [119:0] tbl,
                      input int cps);
    logic [119:0] t;
    t = tbl;
    rst8 = 1'b1;
    i8.enable = 1'b1;
    i8.rate = r;
    i8.mode = m;
    cyc();
    chk("rst_q", 32'(i8.q), 32'hFF);
    chk("rst_sd", 32'(i8.sweep_done), 32'h0);
    rst8 = 1'b0;
    for (int c = 0; c < cps; c++) begin
      cyc();
      chk("lamp_q", 32'(i8.q), 32'hFF);
    end
    for (int k = 0; k < 15; k++) begin
      for (int c = 0; c < cps; c++) begin
        cyc();
        chk("seq_q", 32'(i8.q), 32'(t[8*(14-k) +: 8]));
        chk("seq_sd", 32'(i8.sweep_done),
            32'((k == 13) && (c == cps - 1)));
      end
    end
  endtask

  initial begin
    logic [135:0] t5;
    errors = 0;
    checks = 0;
    rst8 = 1'b1;
    rst5 = 1'b1;
    i8.enable = 1'b0;
    i8.rate = 2'd0;
    i8.mode = 2'd0;
    i5.enable = 1'b0;
    i5.rate = 2'd0;
    i5.mode = 2'd0;
    cyc();

    run8(2'd0, 2'd0,
         120'h01_02_04_08_10_20_40_80_40_20_10_08_04_02_01, 4);
    run8(2'd3, 2'd1,
         120'h81_42_24_18_18_24_42_81_42_24_18_18_24_42_81, 1);
    run8(2'd3, 2'd2,
         120'h01_03_07_0F_1F_3F_7F_FF_7F_3F_1F_0F_07_03_01, 1);
    run8(2'd3, 2'd3,
         120'hFF_00_FF_00_FF_00_FF_00_FF_00_FF_00_FF_00_FF, 1);

    // mode switch 0 -> 2 landing on the tick that would leave pos=5
    rst8 = 1'b1;
    i8.enable = 1'b1;
    i8.rate = 2'd0;
    i8.mode = 2'd0;
    cyc();
    rst8 = 1'b0;
    for (int n = 1; n <= 27; n++) cyc();
    chk("pre_sw_q", 32'(i8.q), 32'h20);
    i8.mode = 2'd2;
    cyc();
    chk("sw_q", 32'(i8.q), 32'h20);
    chk("sw_sd", 32'(i8.sweep_done), 32'h0);
    for (int n = 0; n < 12; n++) begin
      cyc();
      chk("after_sw_q", 32'(i8.q),
          (n < 4) ? 32'h01 : (n < 8) ? 32'h03 : 32'h07);
      chk("after_sw_sd", 32'(i8.sweep_done), 32'h0);
    end

    // freeze with enable low; pos=3, prescaler=0
    i8.enable = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      chk("frz_q", 32'(i8.q), 32'h07);
      chk("frz_sd", 32'(i8.sweep_done), 32'h0);
    end
    i8.enable = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("resume_q", 32'(i8.q), (n < 4) ? 32'h0F : 32'h1F);
    end

    // reset arrives mid-sweep
    run8(2'd0, 2'd2,
         120'h01_03_07_0F_1F_3F_7F_FF_7F_3F_1F_0F_07_03_01, 4);

    // five-LED instance: eight-tick bounce
    t5 = 136'h01_02_04_08_10_08_04_02_01_02_04_08_10_08_04_02_01;
    i5.enable = 1'b1;
    i5.rate = 2'd3;
    i5.mode = 2'd0;
    cyc();
    chk("m5_rst_q", 32'(i5.q), 32'h1F);
    rst5 = 1'b0;
    cyc();
    chk("m5_lamp_q", 32'(i5.q), 32'h1F);
    for (int k = 0; k < 17; k++) begin
      cyc();
      chk("m5_q", 32'(i5.q), 32'(t5[8*(16-k) +: 8]));
      chk("m5_sd", 32'(i5.sweep_done),
          32'((k == 7) || (k == 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
